// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: redirect, instruction ROM port
// and show-ahead decode handshake.
interface fetch_buffer_if #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 18,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               dec_ready;
  logic               dec_valid;
  logic [PC_W-1:0]    dec_pc;
  logic [INSTR_W-1:0] dec_instr;
  logic [CW-1:0]      count;
  logic               halted;

  modport master (
    input  redirect, redirect_pc, rom_data, dec_ready,
    output rom_addr, dec_valid, dec_pc, dec_instr,
    output count, halted
  );

  modport slave (
    output redirect, redirect_pc, rom_data, dec_ready,
    input  rom_addr, dec_valid, dec_pc, dec_instr,
    input  count, halted
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: sequential ROM fetch into
// a small show-ahead FIFO feeding decode.
module fetch_buffer #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 18,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_buffer_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    fpc_q, fpc_d;
  logic [AW-1:0]      head_q, head_d;
  logic [AW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               halted_q, halted_d;
  logic [PC_W-1:0]    pc_mem_q [DEPTH];
  logic [INSTR_W-1:0] ins_mem_q [DEPTH];

  logic full, can_fetch, enq, deq, blank;

  assign full      = (count_q == CW'(DEPTH));
  assign can_fetch = !full && !halted_q && !bus.redirect;
  assign blank     = (bus.rom_data == '0);
  assign enq       = can_fetch && !blank;
  assign deq       = (count_q != '0) && bus.dec_ready
                   && !bus.redirect;

  always_comb begin
    fpc_d    = fpc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (bus.redirect) begin
      fpc_d    = bus.redirect_pc;
      head_d   = tail_q;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (enq) begin
        tail_d = tail_q + AW'(1);
        fpc_d  = fpc_q + PC_W'(1);
      end
      if (can_fetch && blank)
        halted_d = 1'b1;
      if (deq)
        head_d = head_q + AW'(1);
      if (enq && !deq)
        count_d = count_q + CW'(1);
      else if (deq && !enq)
        count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      fpc_q    <= fpc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Storage is not reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem_q[tail_q]  <= fpc_q;
      ins_mem_q[tail_q] <= bus.rom_data;
    end
  end

  assign bus.rom_addr  = fpc_q;
  assign bus.count     = count_q;
  assign bus.halted    = halted_q;
  assign bus.dec_valid = (count_q != '0);
  assign bus.dec_pc    = bus.dec_valid
                       ? pc_mem_q[head_q] : '0;
  assign bus.dec_instr = bus.dec_valid
                       ? ins_mem_q[head_q] : '0;
endmodule
